// File: rtl/debug_unit_pkg.sv
// Shared definitions for the MIPS debug unit (transmit and receive sides).
// Contents: FSM state encoding, dump section encoding, frame header byte.
package debug_unit_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StLatch = 3'd2,
    StSend  = 3'd3,
    StWait  = 3'd4,
    StDone  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    SecHeader = 3'd0,
    SecPc     = 3'd1,
    SecCycles = 3'd2,
    SecRegs   = 3'd3,
    SecMem    = 3'd4
  } section_e;

  // First byte of every dump; the host resynchronizes on it.
  localparam logic [7:0] HeaderByte = 8'hA5;

endpackage

// File: rtl/debug_word_serializer.sv
// Word-to-byte serializer for the debug dump: holds one word and presents it
// MSB byte first.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   load_i        load data_i into the buffer and clear the byte index
//   data_i        word to serialize
//   shift_i       advance to the next byte (shift left by one byte)
//   byte_o        current byte (buffer MSBs)
//   byte_idx_o    index of the current byte within the word
module debug_word_serializer #(
  parameter int unsigned N_BITS      = 8,
  parameter int unsigned N_BITS_WORD = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [N_BITS_WORD-1:0] data_i,
  input  logic                   shift_i,
  output logic [N_BITS-1:0]      byte_o,
  output logic [1:0]             byte_idx_o
);

  logic [N_BITS_WORD-1:0] buf_q, buf_d;
  logic [1:0]             idx_q, idx_d;

  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    if (load_i) begin
      buf_d = data_i;
      idx_d = '0;
    end else if (shift_i) begin
      buf_d = buf_q << N_BITS;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q <= '0;
      idx_q <= '0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
    end
  end

  assign byte_o     = buf_q[N_BITS_WORD-1 -: N_BITS];
  assign byte_idx_o = idx_q;

endmodule

// File: rtl/debug_unit_send.sv
// Transmit half of the MIPS debug unit. On i_send_start it streams a state
// dump over the UART TX: header 0xA5, PC, cycle count, R0..R31 and
// MEM[0..N_MEM_WORDS-1], every word MSB byte first.
// Ports:
//   i_clock, i_reset        clock, async active-high reset
//   i_send_start            one-cycle dump request (ignored while busy)
//   i_pc, i_cycle_count     sampled when their word is latched
//   o_reg_addr/i_reg_data   register-file debug port (1-cycle read latency)
//   o_mem_addr/i_mem_data   data-memory debug port (1-cycle read latency)
//   o_tx_data/o_tx_start    byte and load strobe to the UART TX
//   i_tx_done               UART TX finished the current byte
//   o_busy, o_send_done     status; o_send_done pulses after the last byte
//   o_state                 current FSM state
module debug_unit_send
  import debug_unit_pkg::*;
#(
  parameter int unsigned N_BITS          = 8,
  parameter int unsigned N_BITS_WORD     = 32,
  parameter int unsigned N_BITS_REG      = 5,
  parameter int unsigned N_BITS_MEM_ADDR = 5,
  parameter int unsigned N_MEM_WORDS     = 32,
  parameter int unsigned NB_STATE        = 3
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_send_start,
  input  logic [N_BITS_WORD-1:0]     i_pc,
  input  logic [N_BITS_WORD-1:0]     i_cycle_count,
  output logic [N_BITS_REG-1:0]      o_reg_addr,
  input  logic [N_BITS_WORD-1:0]     i_reg_data,
  output logic [N_BITS_MEM_ADDR-1:0] o_mem_addr,
  input  logic [N_BITS_WORD-1:0]     i_mem_data,
  output logic [N_BITS-1:0]          o_tx_data,
  output logic                       o_tx_start,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_send_done,
  output logic [NB_STATE-1:0]        o_state
);

  localparam int unsigned BytesPerWord = N_BITS_WORD / N_BITS;
  localparam int unsigned IdxW = (N_BITS_REG > N_BITS_MEM_ADDR) ? N_BITS_REG : N_BITS_MEM_ADDR;
  localparam logic [IdxW-1:0] LastReg  = IdxW'((2 ** N_BITS_REG) - 1);
  localparam logic [IdxW-1:0] LastMem  = IdxW'(N_MEM_WORDS - 1);
  localparam logic [1:0]      LastByte = 2'(BytesPerWord - 1);

  state_e          state_q, state_d;
  section_e        section_q, section_d;
  logic [IdxW-1:0] word_idx_q, word_idx_d;

  logic                   ser_load, ser_shift;
  logic [N_BITS_WORD-1:0] latch_data;
  logic [1:0]             byte_idx;
  logic                   word_last_byte, frame_last_word;

  // Source of the word captured in LATCH; the read ports were addressed in LOAD.
  always_comb begin
    latch_data = '0;
    unique case (section_q)
      SecHeader: latch_data = {HeaderByte, {(N_BITS_WORD - 8){1'b0}}};
      SecPc:     latch_data = i_pc;
      SecCycles: latch_data = i_cycle_count;
      SecRegs:   latch_data = i_reg_data;
      SecMem:    latch_data = i_mem_data;
      default:   latch_data = '0;
    endcase
  end

  assign word_last_byte  = (section_q == SecHeader) || (byte_idx == LastByte);
  assign frame_last_word = (section_q == SecMem) && (word_idx_q == LastMem);

  always_comb begin
    state_d    = state_q;
    section_d  = section_q;
    word_idx_d = word_idx_q;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_send_start) begin
          state_d    = StLoad;
          section_d  = SecHeader;
          word_idx_d = '0;
        end
      end
      StLoad:  state_d = StLatch;
      StLatch: begin
        ser_load = 1'b1;
        state_d  = StSend;
      end
      StSend:  state_d = StWait;
      StWait: begin
        if (i_tx_done) begin
          if (!word_last_byte) begin
            ser_shift = 1'b1;
            state_d   = StSend;
          end else if (frame_last_word) begin
            state_d = StDone;
          end else begin
            state_d = StLoad;
            unique case (section_q)
              SecHeader: section_d = SecPc;
              SecPc:     section_d = SecCycles;
              SecCycles: begin
                section_d  = SecRegs;
                word_idx_d = '0;
              end
              SecRegs: begin
                if (word_idx_q == LastReg) begin
                  section_d  = SecMem;
                  word_idx_d = '0;
                end else begin
                  word_idx_d = word_idx_q + 1'b1;
                end
              end
              SecMem:  word_idx_d = word_idx_q + 1'b1;
              default: section_d = SecHeader;
            endcase
          end
        end
      end
      StDone: begin
        // Park on HEADER so both address outputs return to 0 between frames.
        state_d    = StIdle;
        section_d  = SecHeader;
        word_idx_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      section_q  <= SecHeader;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      section_q  <= section_d;
      word_idx_q <= word_idx_d;
    end
  end

  debug_word_serializer #(
    .N_BITS      (N_BITS),
    .N_BITS_WORD (N_BITS_WORD)
  ) u_serializer (
    .clk_i      (i_clock),
    .rst_i      (i_reset),
    .load_i     (ser_load),
    .data_i     (latch_data),
    .shift_i    (ser_shift),
    .byte_o     (o_tx_data),
    .byte_idx_o (byte_idx)
  );

  assign o_reg_addr  = (section_q == SecRegs) ? word_idx_q[N_BITS_REG-1:0] : '0;
  assign o_mem_addr  = (section_q == SecMem) ? word_idx_q[N_BITS_MEM_ADDR-1:0] : '0;
  assign o_tx_start  = (state_q == StSend);
  assign o_busy      = (state_q != StIdle);
  assign o_send_done = (state_q == StDone);
  assign o_state     = NB_STATE'(state_q);

endmodule

// File: tb/tb_debug_unit_send.sv
// Self-checking bench for debug_unit_send: scoreboard of expected frame bytes,
// inline TX model answering i_tx_done 10 cycles after each strobe.
module tb_debug_unit_send;
  import debug_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        send_start;
  logic        tx_done;
  logic [31:0] pc_val;
  logic [31:0] cyc_val;
  logic [31:0] reg_data;
  logic [31:0] mem_data;
  logic [4:0]  reg_addr;
  logic [4:0]  mem_addr;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        send_done;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int         strobe_cyc[$];

  always #5 clk = ~clk;

  // Debug read ports with one cycle of latency.
  always @(posedge clk) begin
    reg_data <= 32'(reg_addr) * 32'h0101_0101;
    mem_data <= 32'hDEAD_0000 + 32'(mem_addr);
  end

  debug_unit_send dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_send_start  (send_start),
    .i_pc          (pc_val),
    .i_cycle_count (cyc_val),
    .o_reg_addr    (reg_addr),
    .i_reg_data    (reg_data),
    .o_mem_addr    (mem_addr),
    .i_mem_data    (mem_data),
    .o_tx_data     (tx_data),
    .o_tx_start    (tx_start),
    .i_tx_done     (tx_done),
    .o_busy        (busy),
    .o_send_done   (send_done),
    .o_state       (state)
  );

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    push_word(pc_val);
    push_word(cyc_val);
    for (int n = 0; n < 32; n++) push_word(32'(n) * 32'h0101_0101);
    for (int n = 0; n < 32; n++) push_word(32'hDEAD_0000 + 32'(n));
  endtask

  // Called at #1 after a rising edge. Requests a frame, plays the TX side and
  // checks every strobed byte against the scoreboard. Returns after o_send_done
  // plus 20 quiet cycles, or right after an asynchronous abort.
  task automatic run_frame(input int inject_at, input int abort_at, input bit stray_load,
                           output int strobes, output int dones, output int extra,
                           output bit aborted);
    int         countdown;
    bit         prev_start;
    bit         finished;
    logic [7:0] exp_b;
    strobes = 0; dones = 0; extra = 0; aborted = 0;
    countdown = 0; prev_start = 0; finished = 0;
    strobe_cyc.delete();
    exp_q.delete();
    push_frame();
    send_start = 1'b1;
    for (int c = 1; c <= 6000 && !finished && !aborted; c++) begin
      @(posedge clk); #1;
      send_start = 1'b0;
      tx_done    = 1'b0;
      if (tx_start) begin
        strobes++;
        strobe_cyc.push_back(c);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_strobe: strobe %0d data %02h, frame already complete", strobes,
                   tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if ({prev_start, busy, tx_data} !== {1'b0, 1'b1, exp_b}) begin
            failures++;
            $display("FAIL byte%0d: got start_prev=%0b busy=%0b data=%02h, want 0 1 %02h",
                     strobes - 1, prev_start, busy, tx_data, exp_b);
          end
        end
        countdown = 10;
        if (strobes == inject_at) send_start = 1'b1;
      end else if (countdown > 0) begin
        countdown--;
        if (strobes == abort_at && countdown == 5) begin
          #2 rst = 1'b1;
          #1;
          checks++;
          if ({busy, tx_start, send_done, tx_data, reg_addr, mem_addr, state} !== '0) begin
            failures++;
            $display("FAIL async_reset_clear: busy=%0b start=%0b done=%0b data=%02h ra=%0d ma=%0d st=%0d, want all 0",
                     busy, tx_start, send_done, tx_data, reg_addr, mem_addr, state);
          end
          aborted = 1;
        end else if (countdown == 0) begin
          tx_done = 1'b1;
        end
      end
      if (stray_load && state == StLoad) tx_done = 1'b1;
      if (send_done) begin
        dones++;
        finished = 1;
      end
      prev_start = tx_start;
    end
    if (!finished && !aborted) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: %0d strobes, no o_send_done within budget, want 265", strobes);
    end
    if (finished) begin
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        tx_done = 1'b0;
        if (tx_start || send_done || busy) extra++;
      end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1; send_start = 1'b0; tx_done = 1'b0;
    pc_val = 32'h0000_0040; cyc_val = 32'h0000_0123;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({tx_data, tx_start, busy, send_done, reg_addr, mem_addr, state} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: data=%02h start=%0b busy=%0b done=%0b ra=%0d ma=%0d st=%0d, want all 0",
                 tx_data, tx_start, busy, send_done, reg_addr, mem_addr, state);
      end
    end
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (tx_start || busy || state != StIdle) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_idle: %0d active cycles after reset, want 0", bad);
    end
  endtask

  task automatic test_stray_idle_done();
    int bad = 0;
    for (int c = 0; c < 6; c++) begin
      tx_done = c[0];
      @(posedge clk); #1;
      if (tx_start || busy || state != StIdle) bad++;
    end
    tx_done = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stray_done_idle: %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_full_dump();
    int s, d, e;
    bit a;
    run_frame(-1, -1, 1'b0, s, d, e, a);
    checks++;
    if ({s, d, e} !== {32'd265, 32'd1, 32'd0}) begin
      failures++;
      $display("FAIL full_dump: strobes=%0d dones=%0d tail_activity=%0d, want 265 1 0", s, d, e);
    end
  endtask

  task automatic test_latency();
    int s, d, e;
    bit a;
    run_frame(-1, -1, 1'b0, s, d, e, a);
    checks++;
    if (strobe_cyc.size() < 6) begin
      failures++;
      $display("FAIL latency_strobes: got %0d strobes, want at least 6", strobe_cyc.size());
    end else begin
      if (strobe_cyc[0] != 3) begin
        failures++;
        $display("FAIL latency_first: strobe %0d cycles after start, want 3", strobe_cyc[0]);
      end
      checks++;
      if (strobe_cyc[1] - strobe_cyc[0] != 13) begin
        failures++;
        $display("FAIL latency_hdr_to_pc: gap %0d, want 13", strobe_cyc[1] - strobe_cyc[0]);
      end
      checks++;
      if (strobe_cyc[2] - strobe_cyc[1] != 11) begin
        failures++;
        $display("FAIL latency_same_word: gap %0d, want 11", strobe_cyc[2] - strobe_cyc[1]);
      end
      checks++;
      if (strobe_cyc[5] - strobe_cyc[4] != 13) begin
        failures++;
        $display("FAIL latency_pc_to_cycles: gap %0d, want 13", strobe_cyc[5] - strobe_cyc[4]);
      end
    end
  endtask

  task automatic test_mid_frame_start();
    int s, d, e;
    bit a;
    pc_val = 32'h1234_5678; cyc_val = 32'h8000_00FF;
    run_frame(50, -1, 1'b0, s, d, e, a);
    checks++;
    if ({s, d, e} !== {32'd265, 32'd1, 32'd0}) begin
      failures++;
      $display("FAIL mid_frame_start: strobes=%0d dones=%0d tail_activity=%0d, want 265 1 0",
               s, d, e);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s, d, e;
    bit a;
    pc_val = 32'h0000_0040; cyc_val = 32'h0000_0123;
    run_frame(-1, 100, 1'b0, s, d, e, a);
    checks++;
    if (!a || s != 100) begin
      failures++;
      $display("FAIL abort_reached: aborted=%0b at strobe %0d, want 1 at 100", a, s);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_frame(-1, -1, 1'b0, s, d, e, a);
    checks++;
    if ({s, d, e} !== {32'd265, 32'd1, 32'd0}) begin
      failures++;
      $display("FAIL restart_after_reset: strobes=%0d dones=%0d tail_activity=%0d, want 265 1 0",
               s, d, e);
    end
  endtask

  task automatic test_stray_load_done();
    int s, d, e;
    bit a;
    run_frame(-1, -1, 1'b1, s, d, e, a);
    checks++;
    if ({s, d, e} !== {32'd265, 32'd1, 32'd0}) begin
      failures++;
      $display("FAIL stray_done_load: strobes=%0d dones=%0d tail_activity=%0d, want 265 1 0",
               s, d, e);
    end
  endtask

  initial begin
    test_reset();
    test_stray_idle_done();
    test_full_dump();
    test_latency();
    test_mid_frame_start();
    test_reset_mid_frame();
    test_stray_load_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
